// File: rtl/mult_result_collector.sv
// Multiplier result collector: credit-controlled FIFO between the multiplier and writeback.
// Optional same-cycle bypass when empty is enabled by defining MULT_COLLECT_BYPASS_EN.
module mult_result_collector #(
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 4,
    parameter int LATENCY       = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       issue_fire_i,
    output logic                       issue_ready_o,
    input  logic                       mult_valid_i,
    input  logic [XLEN-1:0]            mult_result_i,
    input  logic [TRANS_ID_BITS-1:0]   mult_trans_id_i,
    output logic                       wb_valid_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    input  logic                       wb_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int INFL_MAX = DEPTH + LATENCY;
    localparam int IW       = $clog2(INFL_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]          inflight_q, inflight_d;
    logic [IW-1:0]          drop_q, drop_d;
    logic                   overflow_q, overflow_d;

    // Payload storage is not reset; outputs are masked by valid instead.
    logic [XLEN-1:0]          res_mem_q [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_mem_q  [DEPTH];

    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   full;
    logic                   empty;
    logic                   drop_active;
    logic                   push;
    logic                   byp;
    logic                   byp_take;
    logic                   fifo_pop;
    logic                   wr_en;
    logic                   overflow_set;
    logic                   issue_ok;
    logic                   infl_dec;
    logic                   drop_dec;

    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        full        = (count == CW'(DEPTH));
        empty       = (count == '0);
        drop_active = (drop_q != '0);
        push        = mult_valid_i & ~drop_active;

`ifdef MULT_COLLECT_BYPASS_EN
        byp = empty & push & ~flush_i;
`else
        byp = 1'b0;
`endif

        wb_valid_o = ~empty | byp;
        if (!empty) begin
            wb_result_o   = res_mem_q[rd_ptr_q[PW-1:0]];
            wb_trans_id_o = id_mem_q[rd_ptr_q[PW-1:0]];
        end else if (byp) begin
            wb_result_o   = mult_result_i;
            wb_trans_id_o = mult_trans_id_i;
        end else begin
            wb_result_o   = '0;
            wb_trans_id_o = '0;
        end

        // Credits come from registered state only, so no path from issue_fire_i.
        issue_ready_o = (state_q != DRAIN) &&
                        ((32'(count) + 32'(inflight_q)) < 32'(DEPTH));

        fifo_pop     = ~empty & wb_ready_i;
        byp_take     = byp & wb_ready_i;
        wr_en        = push & ~byp_take & (~full | fifo_pop) & ~flush_i;
        overflow_set = push & full & ~fifo_pop & ~flush_i;

        issue_ok = issue_fire_i & issue_ready_o;
        infl_dec = mult_valid_i & ~drop_active & (inflight_q != '0);
        drop_dec = mult_valid_i & drop_active;

        wr_ptr_d   = wr_ptr_q + CW'(wr_en);
        rd_ptr_d   = rd_ptr_q + CW'(fifo_pop & ~flush_i);
        inflight_d = inflight_q + IW'(issue_ok) - IW'(infl_dec);
        drop_d     = drop_q - IW'(drop_dec);
        overflow_d = overflow_q | overflow_set;

        // Flush: everything already in flight becomes drop; an issue this cycle survives.
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = IW'(issue_ok);
            drop_d     = drop_q - IW'(drop_dec) + inflight_q - IW'(infl_dec);
        end

        count_next = wr_ptr_d - rd_ptr_d;

        state_d = state_q;
        case (state_q)
            IDLE:    if (count_next != '0) state_d = ACTIVE;
            ACTIVE:  if (count_next == '0) state_d = IDLE;
            DRAIN:   if (drop_d == '0)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = (drop_d != '0) ? DRAIN : IDLE;
        end

        count_o    = count;
        overflow_o = overflow_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            res_mem_q[wr_ptr_q[PW-1:0]] <= mult_result_i;
            id_mem_q[wr_ptr_q[PW-1:0]]  <= mult_trans_id_i;
        end
    end

endmodule
